// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: fades one RGB LED from off up to a latched colour, holds
// it there, then fades back to off. It can optionally loop with a freshly
// latched colour.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | duties at 0, waiting for START (STOP has priority)
// FADE_UP   | one step toward the latched target per tick
// HOLD_ST   | parked at target for latched HOLD + 1 ticks
// FADE_DOWN | one step toward 0 per tick; DONE pulses when all reach 0
module rgb_fade_sequencer #(
  parameter int CH_W     = 5,
  parameter int STEP_DIV = 100000,
  parameter int HOLD_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              LOOP,
  input  logic [3*CH_W-1:0] TARGET,
  input  logic [HOLD_W-1:0] HOLD,
  output logic [CH_W-1:0]   DUTY_R,
  output logic [CH_W-1:0]   DUTY_G,
  output logic [CH_W-1:0]   DUTY_B,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, FADE_UP, HOLD_ST, FADE_DOWN} state_t;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [HOLD_W-1:0]          hold_cnt, hold_cnt_n;
  logic [HOLD_W-1:0]          hold_lat, hold_lat_n;
  // Channel index 2 = R, 1 = G, 0 = B, matching the TARGET packing.
  logic [2:0][CH_W-1:0]       tgt, tgt_n;
  logic [2:0][CH_W-1:0]       duty, duty_n;
  logic                       done_n;
  logic                       tick;
  logic                       at_target;
  logic                       all_zero;

  assign tick      = (cnt == CNT_LAST);
  assign at_target = (duty == tgt);
  assign all_zero  = (duty == '0);
  assign BUSY      = (state != IDLE);
  assign DUTY_R    = duty[2];
  assign DUTY_G    = duty[1];
  assign DUTY_B    = duty[0];

  // Next-state, step counter and duty stepping; STOP outranks a coincident tick.
  always_comb begin
    state_n    = state;
    cnt_n      = tick ? '0 : cnt + CNT_W'(1);
    hold_cnt_n = hold_cnt;
    hold_lat_n = hold_lat;
    tgt_n      = tgt;
    duty_n     = duty;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (START && !STOP) begin
          tgt_n      = TARGET;
          hold_lat_n = HOLD;
          state_n    = FADE_UP;
        end
      end
      FADE_UP: begin
        if (STOP) begin
          state_n = FADE_DOWN;
        end else if (tick) begin
          if (at_target) begin
            state_n    = HOLD_ST;
            hold_cnt_n = '0;
          end else begin
            for (int c = 0; c < 3; c++) begin
              if (duty[c] < tgt[c]) duty_n[c] = duty[c] + CH_W'(1);
            end
          end
        end
      end
      HOLD_ST: begin
        if (STOP) begin
          state_n = FADE_DOWN;
        end else if (tick) begin
          if (hold_cnt == hold_lat) state_n = FADE_DOWN;
          else hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      FADE_DOWN: begin
        if (tick) begin
          if (all_zero) begin
            done_n = 1'b1;
            if (LOOP) begin
              tgt_n      = TARGET;
              hold_lat_n = HOLD;
              state_n    = FADE_UP;
            end else begin
              state_n = IDLE;
            end
          end else begin
            for (int c = 0; c < 3; c++) begin
              if (duty[c] != '0) duty_n[c] = duty[c] - CH_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Every phase gets a full STEP_DIV cycles before its first tick.
    if (state_n != state) cnt_n = '0;
  end

  // State and datapath registers; reset drops straight to off with no fade.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      hold_lat <= '0;
      tgt      <= '0;
      duty     <= '0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hold_cnt <= hold_cnt_n;
      hold_lat <= hold_lat_n;
      tgt      <= tgt_n;
      duty     <= duty_n;
      DONE     <= done_n;
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer: closed-form reference model,
// per-cycle comparison, directed scenarios with literal expectations, then
// randomized control traffic.
module tb_rgb_fade_sequencer;
  localparam int CH_W   = 5;
  localparam int SD     = 4;
  localparam int HOLD_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              STOP = 1'b0;
  logic              LOOP = 1'b0;
  logic [3*CH_W-1:0] TARGET = '0;
  logic [HOLD_W-1:0] HOLD = '0;
  logic [CH_W-1:0]   DUTY_R, DUTY_G, DUTY_B;
  logic              BUSY, DONE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rgb_fade_sequencer #(.CH_W(CH_W), .STEP_DIV(SD), .HOLD_W(HOLD_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
    .TARGET(TARGET), .HOLD(HOLD),
    .DUTY_R(DUTY_R), .DUTY_G(DUTY_G), .DUTY_B(DUTY_B),
    .BUSY(BUSY), .DONE(DONE)
  );

  // Reference model: phase plus edges-since-phase-entry; duties are derived in
  // closed form from the number of elapsed ticks (index 0=R, 1=G, 2=B).
  int m_phase = 0;  // 0 idle, 1 up, 2 hold, 3 down
  int m_age   = 0;
  int m_hold  = 0;
  int m_t[3]    = '{0, 0, 0};
  int m_base[3] = '{0, 0, 0};
  int m_d[3]    = '{0, 0, 0};
  int cur[3]    = '{0, 0, 0};
  bit m_done  = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [3*CH_W-1:0] rgb(input int r, input int g, input int b);
    return {CH_W'(r), CH_W'(g), CH_W'(b)};
  endfunction

  task automatic m_latch();
    m_t[0] = int'(TARGET[3*CH_W-1:2*CH_W]);
    m_t[1] = int'(TARGET[2*CH_W-1:CH_W]);
    m_t[2] = int'(TARGET[CH_W-1:0]);
    m_hold = int'(HOLD);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = 0; m_age = 0; m_hold = 0; m_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_t[c] = 0; m_base[c] = 0; m_d[c] = 0;
      end
    end else begin
      cur = m_d;
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (START && !STOP) begin
          m_latch();
          m_phase = 1; m_age = 0;
        end
      end else begin
        m_age++;
        case (m_phase)
          1: begin
            if (STOP) begin
              m_base = cur; m_phase = 3; m_age = 0;
            end else if (m_age == (max3(m_t[0], m_t[1], m_t[2]) + 1) * SD) begin
              m_phase = 2; m_age = 0;
            end
          end
          2: begin
            if (STOP || m_age == (m_hold + 1) * SD) begin
              m_base = cur; m_phase = 3; m_age = 0;
            end
          end
          default: begin
            if (m_age == (max3(m_base[0], m_base[1], m_base[2]) + 1) * SD) begin
              m_done = 1'b1;
              m_age = 0;
              if (LOOP) begin
                m_latch();
                m_phase = 1;
              end else begin
                m_phase = 0;
              end
            end
          end
        endcase
      end
      for (int c = 0; c < 3; c++) begin
        case (m_phase)
          0: m_d[c] = 0;
          1: m_d[c] = (m_age / SD < m_t[c]) ? m_age / SD : m_t[c];
          2: m_d[c] = m_t[c];
          default: m_d[c] = (m_base[c] > m_age / SD) ? m_base[c] - m_age / SD : 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    chk("cyc_duty_r", int'(DUTY_R), m_d[0]);
    chk("cyc_duty_g", int'(DUTY_G), m_d[1]);
    chk("cyc_duty_b", int'(DUTY_B), m_d[2]);
    chk("cyc_busy", int'(BUSY), (m_phase != 0) ? 1 : 0);
    chk("cyc_done", int'(DONE), int'(m_done));
  end

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string tag, input int r, input int g, input int b,
                     input int busy, input int done);
    chk({tag, "_r"}, int'(DUTY_R), r);
    chk({tag, "_g"}, int'(DUTY_G), g);
    chk({tag, "_b"}, int'(DUTY_B), b);
    chk({tag, "_busy"}, int'(BUSY), busy);
    chk({tag, "_done"}, int'(DONE), done);
    chk({tag, "_model"}, m_d[0] * 4096 + m_d[1] * 64 + m_d[2], r * 4096 + g * 64 + b);
    chk({tag, "_model_busy"}, (m_phase != 0) ? 1 : 0, busy);
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_seq(input logic [3*CH_W-1:0] t, input logic [HOLD_W-1:0] h,
                           input logic lp);
    @(negedge CLK);
    TARGET = t; HOLD = h; LOOP = lp; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("idle_timeout", int'(BUSY), 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    lit("reset", 0, 0, 0, 0, 0);

    // Basic sequence R=3 G=1 B=0, HOLD=0
    start_seq(rgb(3, 1, 0), 4'd0, 1'b0);
    lit("basic_e0", 0, 0, 0, 1, 0);
    go(3);  lit("basic_e3", 0, 0, 0, 1, 0);
    go(1);  lit("basic_e4", 1, 1, 0, 1, 0);
    go(4);  lit("basic_e8", 2, 1, 0, 1, 0);
    go(4);  lit("basic_e12", 3, 1, 0, 1, 0);
    go(4);  lit("basic_e16", 3, 1, 0, 1, 0);
    go(4);  lit("basic_e20", 3, 1, 0, 1, 0);
    go(4);  lit("basic_e24", 2, 0, 0, 1, 0);
    go(4);  lit("basic_e28", 1, 0, 0, 1, 0);
    go(4);  lit("basic_e32", 0, 0, 0, 1, 0);
    go(3);  lit("basic_e35", 0, 0, 0, 1, 0);
    go(1);  lit("basic_e36", 0, 0, 0, 0, 1);
    go(1);  lit("basic_e37", 0, 0, 0, 0, 0);

    // Hold length: HOLD=3 -> four ticks in hold
    start_seq(rgb(1, 1, 1), 4'd3, 1'b0);
    go(8);  lit("hold_e8", 1, 1, 1, 1, 0);
    go(19); lit("hold_e27", 1, 1, 1, 1, 0);
    go(1);  lit("hold_e28", 0, 0, 0, 1, 0);
    go(4);  lit("hold_e32", 0, 0, 0, 0, 1);

    // STOP mid-fade at R=5
    start_seq(rgb(31, 0, 0), 4'd0, 1'b0);
    go(20); lit("stop_e20", 5, 0, 0, 1, 0);
    go(1);  STOP = 1'b1;
    go(1);  lit("stop_e22", 5, 0, 0, 1, 0);
    STOP = 1'b0;
    go(3);  lit("stop_e25", 5, 0, 0, 1, 0);
    go(1);  lit("stop_e26", 4, 0, 0, 1, 0);
    go(16); lit("stop_e42", 0, 0, 0, 1, 0);
    go(3);  lit("stop_e45", 0, 0, 0, 1, 0);
    go(1);  lit("stop_e46", 0, 0, 0, 0, 1);

    // LOOP re-latches TARGET at DONE
    start_seq(rgb(0, 1, 0), 4'd0, 1'b1);
    go(2);  TARGET = rgb(0, 2, 0);
    go(6);  lit("loop_e8", 0, 1, 0, 1, 0);
    go(12); lit("loop_e20", 0, 0, 0, 1, 1);
    go(8);  lit("loop_e28", 0, 2, 0, 1, 0);
    LOOP = 1'b0;
    wait_idle(500);

    // START and STOP together in IDLE
    @(negedge CLK);
    START = 1'b1; STOP = 1'b1;
    go(1);  lit("startstop", 0, 0, 0, 0, 0);
    START = 1'b0; STOP = 1'b0;
    go(4);  lit("startstop_after", 0, 0, 0, 0, 0);

    // START during hold with a different TARGET is ignored
    start_seq(rgb(1, 2, 3), 4'd5, 1'b0);
    go(18); lit("ign_e18", 1, 2, 3, 1, 0);
    TARGET = rgb(31, 31, 31); HOLD = 4'd0; START = 1'b1;
    go(1);  START = 1'b0;
    go(11); lit("ign_e30", 1, 2, 3, 1, 0);
    go(13); lit("ign_e43", 1, 2, 3, 1, 0);
    go(1);  lit("ign_e44", 0, 1, 2, 1, 0);
    wait_idle(500);

    // Asynchronous reset mid fade-up with R=2
    start_seq(rgb(5, 0, 0), 4'd0, 1'b0);
    go(8);  lit("rst_e8", 2, 0, 0, 1, 0);
    #2 RST = 1'b1;
    #1 lit("rst_async", 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    go(6);  lit("rst_after", 0, 0, 0, 0, 0);

    // Randomized control traffic
    for (int i = 0; i < 8000; i++) begin
      @(negedge CLK);
      START = ($urandom_range(0, 29) == 0);
      STOP  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) LOOP = ~LOOP;
      if ($urandom_range(0, 19) == 0) TARGET = (3*CH_W)'($urandom);
      if ($urandom_range(0, 99) == 0) TARGET = '0;
      if ($urandom_range(0, 19) == 0) HOLD = HOLD_W'($urandom);
    end
    @(negedge CLK);
    START = 1'b0; STOP = 1'b0; LOOP = 1'b0;
    wait_idle(2000);
    go(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Controller that drives the duty-cycle inputs of one RGB PWM LED channel. It fades from off to a latched target colour, holds there, then fades back to off, with optional looping. It sits between the switch/control logic and the PWM generator in the LED top level, replacing direct switch-to-duty wiring. A single block instance sequences one LED; the top level instantiates one per LED.

Parameters:
CH_W, 5, width of each colour duty channel (R, G, B)
STEP_DIV, 100000, CLK cycles per fade step ("tick"); must be >= 2
HOLD_W, 4, width of the hold-length field

Ports:
CLK  input  1  system clock, all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  level-sampled request to begin a sequence; honoured only in IDLE
STOP  input  1  level-sampled request to abort to fade-down
LOOP  input  1  when high at sequence end, restart instead of idling
TARGET  input  3*CH_W  target colour {R,G,B}: R = [3*CH_W-1:2*CH_W], G = middle field, B = [CH_W-1:0]
HOLD  input  HOLD_W  number of extra ticks to hold at the target
DUTY_R  output  CH_W  red duty value to the PWM
DUTY_G  output  CH_W  green duty value to the PWM
DUTY_B  output  CH_W  blue duty value to the PWM
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse when fade-down completes

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high. On reset: state IDLE; DUTY_R/G/B = 0; BUSY = 0; DONE = 0; tick counter = 0; hold counter = 0; latched target = 0; latched hold = 0. Reset mid-sequence takes effect immediately, with no fade-out.
- States: IDLE, FADE_UP, HOLD_ST, FADE_DOWN.
- Tick counter:
  - Counts 0..STEP_DIV-1 only in non-IDLE states.
  - tick = (count == STEP_DIV-1).
  - Clears to 0 on every state change.
  - The first tick after entering a state therefore occurs on the STEP_DIV-th edge in that state.
- IDLE:
  - If START=1 and STOP=0 on an edge: latch TARGET and HOLD, then enter FADE_UP on that edge.
  - START and STOP both high: STOP wins and the block stays IDLE.
  - STOP alone: no effect.
- FADE_UP, evaluated on each tick:
  - If every duty equals its latched target, enter HOLD_ST and clear the hold counter.
  - Otherwise, every channel below its target increments by 1; channels at target stay unchanged.
  - Duties never exceed the target and never wrap.
- HOLD_ST, on each tick:
  - If hold counter == latched HOLD, enter FADE_DOWN.
  - Otherwise increment the hold counter.
  - HOLD=0 leaves after 1 tick; HOLD=N leaves after N+1 ticks.
- FADE_DOWN, on each tick:
  - If all duties are 0: pulse DONE for exactly that one cycle.
    - If LOOP=1: re-latch TARGET and HOLD and enter FADE_UP.
    - Otherwise enter IDLE.
  - Otherwise, every nonzero channel decrements by 1 and never underflows.
- STOP:
  - In FADE_UP or HOLD_ST: enter FADE_DOWN on the same edge. Duties are frozen at their current values and the tick counter clears.
  - In FADE_DOWN: ignored.
  - STOP takes priority over a tick on the same edge.
- START outside IDLE: ignored. TARGET and HOLD changes outside latch points: ignored.
- Outputs are registered and change only on ticks, state entry, or reset. BUSY derives from the registered state.
- A zero target is legal: FADE_UP exits on its first tick, and FADE_DOWN ends on its first tick.

Test Plan:
1. Reset: assert RST mid-FADE_UP with DUTY_R=2 -> DUTY_R/G/B=0, BUSY=0, DONE=0 immediately, without waiting for a CLK edge; after release the block stays IDLE.
2. Basic sequence, STEP_DIV=4, TARGET R=3/G=1/B=0, HOLD=0, LOOP=0; START pulsed at edge 0:
   - Up-fade: at edge 4, R=1 and G=1; edge 8, R=2; edge 12, R=3; edge 16, enter HOLD_ST.
   - Hold: edge 20, enter FADE_DOWN.
   - Down-fade: edge 24, R=2 and G=0; edge 28, R=1; edge 32, R=0.
   - End: edge 36, DONE=1 for one cycle, then IDLE with BUSY=0.
3. Hold length: STEP_DIV=4, TARGET all=1, HOLD=3 -> 4 ticks (16 cycles) spent in HOLD_ST before FADE_DOWN.
4. STOP mid-fade: STEP_DIV=4, TARGET R=31; assert STOP when R=5 -> R freezes at 5, then decrements at 4-cycle intervals to 0; DONE follows 4 cycles after R reaches 0.
5. LOOP and priority:
   - LOOP=1 with TARGET changed to G=2 during the first run -> the second run fades G to 2, because TARGET is re-latched at DONE.
   - START+STOP together in IDLE -> stays IDLE.
6. Ignored START: pulse START during HOLD_ST with a different TARGET -> the sequence is unchanged and the original target values are held.
